rst_sequencer: RTL and testbench
================================

Name: rst_sequencer

Overview:
Parametrised reset sequencer. It stretches the board/bench reset for a fixed number of cycles, then releases N reset domains in a staggered order, for example memory controller, then cache, then core, then IO. It sits directly below riscv_top's clock/reset inputs and replaces ad-hoc fixed-length reset pulses. It also supports a synchronous soft-reset request and an optional run-time watchdog that flags a stalled simulation or hardware run.

Parameters:
NUM_CH, 4, number of reset channels (1..16)
HOLD_CYCLES, 25, clock edges all channels stay asserted after rst deasserts (>=1)
STAGGER, 4, clock edges between successive channel releases (0 = all release together)
CNT_W, 8, width of sequencing counter; must hold HOLD_CYCLES+(NUM_CH-1)*STAGGER
TIMEOUT, 0, RUN-state cycles before timeout asserts (0 = watchdog disabled)
TO_W, 32, width of watchdog counter; must hold TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
soft_rst_req  in  1  synchronous soft-reset request, sampled each rising edge
rst_out  out  NUM_CH  per-channel active-high reset; bit 0 releases first
all_released  out  1  high when every rst_out bit is 0
timeout  out  1  sticky watchdog flag
run_cycles  out  TO_W  cycles spent in RUN since last release; saturates at all-ones

Behaviour:
- Async reset (rst=1), effective immediately and independent of clk:
  - rst_out = all ones, all_released=0, timeout=0, run_cycles=0.
  - State=HOLD, seq counter=0.
  - Reset mid-sequence or mid-RUN behaves identically.
- Edge numbering: edge k = k-th rising clk edge with rst low (first edge k=1).
- States HOLD -> RELEASE -> RUN. Seq counter increments by 1 each edge in HOLD/RELEASE; the value after edge k equals k.
- HOLD: at the edge where count reaches HOLD_CYCLES, clear rst_out[0] and enter RELEASE.
  - If NUM_CH=1, or STAGGER=0, clear all bits and go straight to RUN.
- RELEASE: rst_out[i] clears at edge HOLD_CYCLES + i*STAGGER.
  - Release is monotonic: bit i never clears before bit i-1.
  - At the edge that clears bit NUM_CH-1, enter RUN and set all_released=1 on that same edge.
- RUN:
  - run_cycles increments every edge, saturating.
  - If TIMEOUT!=0, timeout goes 1 on the edge where run_cycles becomes TIMEOUT and stays 1 until rst or soft reset.
  - run_cycles and timeout are 0 in HOLD/RELEASE.
- soft_rst_req=1 at an edge in RELEASE or RUN:
  - Same edge: rst_out = all ones, all_released=0, timeout=0, run_cycles=0, seq counter=0, state=HOLD.
  - Subsequent release timing is identical to post-rst timing, counting that edge as edge 0.
- soft_rst_req=1 in HOLD: seq counter restarts at 0, extending the hold.
- soft_rst_req held high: sequencer stays in HOLD.
- soft_rst_req is ignored while rst=1.
- All outputs are registered; no combinational path from soft_rst_req to rst_out.

Test Plan:
- Defaults; rst high 25 cycles, then low. Required:
  - rst_out=4'b1111 through edge 24.
  - 4'b1110 after edge 25, 4'b1100 after edge 29, 4'b1000 after edge 33, 4'b0000 after edge 37.
  - all_released rises at edge 37.
- STAGGER=0, HOLD_CYCLES=3 -> rst_out 4'b1111 -> 4'b0000 at edge 3; all_released=1 at edge 3.
- TIMEOUT=100, defaults otherwise -> run_cycles=1 after edge 38; timeout rises at edge 137 (run_cycles=100) and stays high until soft_rst_req.
- soft_rst_req pulsed at edge 50 (RUN), TIMEOUT=100 -> rst_out=4'b1111 and timeout=0 at edge 50; rst_out[0] clears at edge 75; all_released at edge 87.
- rst asserted asynchronously mid-RELEASE (after edge 30, between edges) -> rst_out=4'b1111 before next clk edge; sequence restarts from edge 1 after rst falls.
- soft_rst_req held high edges 10..40, released at edge 41 -> rst_out stays 4'b1111; rst_out[0] clears at edge 40+25=65.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer: stretches the incoming reset for HOLD_CYCLES edges, then
// releases NUM_CH reset domains one after another, STAGGER edges apart.
// Also provides a synchronous soft-reset request and an optional watchdog
// that counts cycles spent in RUN and flags a stalled run.
module rst_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 25,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 0,
    parameter int TO_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_released,
    output logic              timeout,
    output logic [TO_W-1:0]   run_cycles
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    // Edge count at which the last channel comes out of reset.
    localparam int LAST_RELEASE = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_END = CNT_W'(LAST_RELEASE);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   seq_cnt;
    logic [CNT_W-1:0]   seq_cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_CH-1:0]  rst_out_next;
    logic               all_released_next;
    logic               timeout_next;
    logic [TO_W-1:0]    run_cycles_next;

    // Next-state and next-output logic; every output is registered, so the
    // soft request only ever reaches rst_out through the flops below.
    always_comb begin
        state_next        = state;
        seq_cnt_next      = seq_cnt;
        rst_out_next      = rst_out;
        all_released_next = all_released;
        timeout_next      = timeout;
        run_cycles_next   = run_cycles;
        cnt_inc           = seq_cnt + CNT_W'(1);

        if (soft_rst_req) begin
            state_next        = S_HOLD;
            seq_cnt_next      = '0;
            rst_out_next      = '1;
            all_released_next = 1'b0;
            timeout_next      = 1'b0;
            run_cycles_next   = '0;
        end else begin
            case (state)
                S_HOLD, S_RELEASE: begin
                    seq_cnt_next = cnt_inc;
                    // A channel is out of reset once the count has passed its
                    // threshold; thresholds rise with channel index, so the
                    // release order is monotonic by construction.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cnt_inc >= CNT_W'(HOLD_CYCLES + i * STAGGER)) begin
                            rst_out_next[i] = 1'b0;
                        end
                    end
                    // With STAGGER=0 or one channel the last release coincides
                    // with the end of hold, so RUN is entered directly.
                    if (cnt_inc == LAST_END) begin
                        state_next        = S_RUN;
                        rst_out_next      = '0;
                        all_released_next = 1'b1;
                    end else if (cnt_inc == HOLD_END) begin
                        state_next = S_RELEASE;
                    end
                end
                S_RUN: begin
                    if (run_cycles != '1) begin
                        run_cycles_next = run_cycles + TO_W'(1);
                    end
                    if ((TIMEOUT != 0) && (run_cycles_next == TO_LIMIT)) begin
                        timeout_next = 1'b1;
                    end
                end
                default: begin
                    state_next = S_HOLD;
                end
            endcase
        end
    end

    // State and output registers; the board reset forces the full reset
    // pattern immediately, regardless of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_HOLD;
            seq_cnt      <= '0;
            rst_out      <= '1;
            all_released <= 1'b0;
            timeout      <= 1'b0;
            run_cycles   <= '0;
        end else begin
            state        <= state_next;
            seq_cnt      <= seq_cnt_next;
            rst_out      <= rst_out_next;
            all_released <= all_released_next;
            timeout      <= timeout_next;
            run_cycles   <= run_cycles_next;
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: drives two sequencer configurations from a shared
// clock/reset/soft-request and checks them against a reference model that
// only tracks "edges since the sequence last restarted".
module tb_rst_sequencer;

    // Configuration A: default staggered release with watchdog enabled.
    localparam int A_CH   = 4;
    localparam int A_HOLD = 25;
    localparam int A_STAG = 4;
    localparam int A_TO   = 100;
    localparam int A_TOW  = 32;

    // Configuration B: simultaneous release, narrow saturating run counter.
    localparam int B_CH   = 4;
    localparam int B_HOLD = 3;
    localparam int B_STAG = 0;
    localparam int B_TO   = 0;
    localparam int B_TOW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic soft_rst_req = 1'b0;

    logic [A_CH-1:0]  a_rst_out;
    logic             a_all_released;
    logic             a_timeout;
    logic [A_TOW-1:0] a_run_cycles;

    logic [B_CH-1:0]  b_rst_out;
    logic             b_all_released;
    logic             b_timeout;
    logic [B_TOW-1:0] b_run_cycles;

    rst_sequencer #(
        .NUM_CH(A_CH), .HOLD_CYCLES(A_HOLD), .STAGGER(A_STAG),
        .CNT_W(8), .TIMEOUT(A_TO), .TO_W(A_TOW)
    ) dut_a (
        .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
        .rst_out(a_rst_out), .all_released(a_all_released),
        .timeout(a_timeout), .run_cycles(a_run_cycles)
    );

    rst_sequencer #(
        .NUM_CH(B_CH), .HOLD_CYCLES(B_HOLD), .STAGGER(B_STAG),
        .CNT_W(4), .TIMEOUT(B_TO), .TO_W(B_TOW)
    ) dut_b (
        .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req),
        .rst_out(b_rst_out), .all_released(b_all_released),
        .timeout(b_timeout), .run_cycles(b_run_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a_rst;
        logic [63:0] a_all;
        logic [63:0] a_to;
        logic [63:0] a_run;
        logic [63:0] b_rst;
        logic [63:0] b_all;
        logic [63:0] b_to;
        logic [63:0] b_run;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   t_edges = 0;
    int   cyc = 0;

    // Reference model: everything follows from the number of edges since the
    // last restart point (rst edge or soft request edge counts as edge 0).
    function automatic logic [63:0] model_rst(int tt, int ch, int hold, int stag);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < ch; i++) v[i] = (tt < hold + i * stag);
        return v;
    endfunction

    function automatic logic [63:0] model_all(int tt, int ch, int hold, int stag);
        return (tt >= hold + (ch - 1) * stag) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] model_run(int tt, int ch, int hold, int stag, int tow);
        longint last;
        longint r;
        longint maxv;
        last = hold + (ch - 1) * stag;
        maxv = (64'd1 << tow) - 1;
        r = (tt > last) ? longint'(tt) - last : 0;
        return (r > maxv) ? maxv : r;
    endfunction

    function automatic logic [63:0] model_to(int tt, int ch, int hold, int stag, int tow, int to);
        if (to == 0) return 64'd0;
        return (model_run(tt, ch, hold, stag, tow) >= longint'(to)) ? 64'd1 : 64'd0;
    endfunction

    function automatic exp_t build_expect(int tt, int c);
        exp_t e;
        e.a_rst = model_rst(tt, A_CH, A_HOLD, A_STAG);
        e.a_all = model_all(tt, A_CH, A_HOLD, A_STAG);
        e.a_run = model_run(tt, A_CH, A_HOLD, A_STAG, A_TOW);
        e.a_to  = model_to(tt, A_CH, A_HOLD, A_STAG, A_TOW, A_TO);
        e.b_rst = model_rst(tt, B_CH, B_HOLD, B_STAG);
        e.b_all = model_all(tt, B_CH, B_HOLD, B_STAG);
        e.b_run = model_run(tt, B_CH, B_HOLD, B_STAG, B_TOW);
        e.b_to  = model_to(tt, B_CH, B_HOLD, B_STAG, B_TOW, B_TO);
        e.cyc   = c;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected, input int c);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d",
                     name, c, actual, expected);
        end
    endtask

    // Drive one clock's worth of inputs and queue the outputs expected after
    // the following rising edge.
    task automatic applyStimulus(input logic r, input logic s);
        @(negedge clk);
        rst = r;
        soft_rst_req = s;
        cyc++;
        if (r || s) t_edges = 0;
        else t_edges++;
        exp_q.push_back(build_expect(t_edges, cyc));
    endtask

    // Raise rst between edges and confirm the outputs react without a clock.
    task automatic asyncResetCheck();
        @(posedge clk);
        #2;
        rst = 1'b1;
        t_edges = 0;
        #1;
        checkOutput("async_a_rst_out", 64'(a_rst_out), 64'hF, cyc);
        checkOutput("async_a_all_released", 64'(a_all_released), 64'd0, cyc);
        checkOutput("async_b_rst_out", 64'(b_rst_out), 64'hF, cyc);
        checkOutput("async_b_all_released", 64'(b_all_released), 64'd0, cyc);
        checkOutput("async_b_run_cycles", 64'(b_run_cycles), 64'd0, cyc);
    endtask

    // Monitor: one expectation per rising edge, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("a_rst_out", 64'(a_rst_out), mon_e.a_rst, mon_e.cyc);
            checkOutput("a_all_released", 64'(a_all_released), mon_e.a_all, mon_e.cyc);
            checkOutput("a_timeout", 64'(a_timeout), mon_e.a_to, mon_e.cyc);
            checkOutput("a_run_cycles", 64'(a_run_cycles), mon_e.a_run, mon_e.cyc);
            checkOutput("b_rst_out", 64'(b_rst_out), mon_e.b_rst, mon_e.cyc);
            checkOutput("b_all_released", 64'(b_all_released), mon_e.b_all, mon_e.cyc);
            checkOutput("b_timeout", 64'(b_timeout), mon_e.b_to, mon_e.cyc);
            checkOutput("b_run_cycles", 64'(b_run_cycles), mon_e.b_run, mon_e.cyc);
        end
    end

    initial begin
        logic r;
        logic s;

        $display("[TB] start");

        // Board reset for 25 cycles, then a full sequence through timeout.
        repeat (25) applyStimulus(1'b1, 1'b0);
        repeat (140) applyStimulus(1'b0, 1'b0);

        // Soft request clears the sticky timeout.
        applyStimulus(1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0);

        // Fresh release, soft request at edge 50 while in RUN.
        applyStimulus(1'b1, 1'b0);
        repeat (49) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (100) applyStimulus(1'b0, 1'b0);

        // Asynchronous reset in the middle of the staggered release.
        applyStimulus(1'b1, 1'b0);
        repeat (30) applyStimulus(1'b0, 1'b0);
        asyncResetCheck();
        repeat (3) applyStimulus(1'b1, 1'b0);
        repeat (40) applyStimulus(1'b0, 1'b0);

        // Soft request held high for edges 10..40 keeps everything in hold.
        applyStimulus(1'b1, 1'b0);
        repeat (9) applyStimulus(1'b0, 1'b0);
        repeat (31) applyStimulus(1'b0, 1'b1);
        repeat (50) applyStimulus(1'b0, 1'b0);

        // Random mix of rare board resets and soft requests.
        repeat (500) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 59) == 0);
            applyStimulus(r, s);
        end

        // Let the monitor consume the last expectations, bounded.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
